// File: rtl/la_pkg.sv
`default_nettype none
// ============================================================================
// Package     : la_pkg
// Description : Shared constants for the logic-analyzer host link: default
//               baud divisor, ack codes and command opcodes.
// Revision    : 1.0 - initial release
// ============================================================================
package la_pkg;

    // 115200 baud from a 100 MHz clock
    localparam int BAUD_DIV_DEFAULT = 868;

    // Response codes returned by the analyzer
    localparam logic [7:0] ACK_POS = 8'hA5;
    localparam logic [7:0] ACK_NEG = 8'hEE;

    // Command opcodes (cmd[15:8])
    localparam logic [7:0] SET_TRG_CFG = 8'h40;
    localparam logic [7:0] DUMP_CH1    = 8'h81;

endpackage
`default_nettype wire

// File: rtl/comm_uart.sv
`default_nettype none
// ============================================================================
// Module      : comm_uart
// Description : 8N1 UART, independent transmitter and receiver. The tx side
//               accepts a new byte on the same cycle tx_done fires so frames
//               can be chained with no idle gap.
// Revision    : 1.0 - initial release
// ============================================================================
module comm_uart
    import la_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       tx_done,
    output logic       TX,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic       rdy,
    output logic [7:0] rx_data
);

    localparam int                 c_cnt_w    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_bit_end  = c_cnt_w'(BAUD_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_half_end = c_cnt_w'(BAUD_DIV / 2 - 1);

    localparam logic [1:0] c_rx_idle  = 2'd0;
    localparam logic [1:0] c_rx_start = 2'd1;
    localparam logic [1:0] c_rx_data  = 2'd2;
    localparam logic [1:0] c_rx_stop  = 2'd3;

    // ---------------- transmitter ----------------
    logic [9:0]         r_tx_shift;
    logic               r_tx_busy;
    logic [c_cnt_w-1:0] r_tx_cnt;
    logic [3:0]         r_tx_bit;

    // Shift out {stop, data, start}; bit 0 of the shifter is the line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_shift <= '1;
            r_tx_busy  <= 1'b0;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
        end else if (trmt) begin
            r_tx_shift <= {1'b1, tx_data, 1'b0};
            r_tx_busy  <= 1'b1;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
        end else if (r_tx_busy) begin
            if (r_tx_cnt == c_bit_end) begin
                r_tx_cnt <= '0;
                if (r_tx_bit == 4'd9) begin
                    r_tx_busy <= 1'b0;
                end else begin
                    r_tx_shift <= {1'b1, r_tx_shift[9:1]};
                    r_tx_bit   <= r_tx_bit + 4'd1;
                end
            end else begin
                r_tx_cnt <= r_tx_cnt + 1'b1;
            end
        end
    end

    // Last cycle of the stop bit
    assign tx_done = r_tx_busy && (r_tx_cnt == c_bit_end) && (r_tx_bit == 4'd9);
    assign TX      = r_tx_shift[0];

    // ---------------- receiver ----------------
    logic               r_rx_meta;
    logic               r_rx_sync;
    logic               r_rx_prev;
    logic [1:0]         r_rx_state;
    logic [1:0]         w_rx_nxt;
    logic [c_cnt_w-1:0] r_rx_cnt;
    logic [2:0]         r_rx_bit;
    logic [7:0]         r_rx_shift;
    logic               r_rdy;
    logic [7:0]         r_rx_data;
    logic               w_rx_fall;
    logic               w_cnt_clr;
    logic               w_sample;
    logic               w_frame_start;
    logic               w_byte_ok;

    // Two-flop synchronizer plus one history flop for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= RX;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    assign w_rx_fall = r_rx_prev & ~r_rx_sync;

    // Receiver state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rx_state <= c_rx_idle;
        else        r_rx_state <= w_rx_nxt;
    end

    // Receiver next state and datapath strobes
    always_comb begin
        w_rx_nxt      = r_rx_state;
        w_cnt_clr     = 1'b0;
        w_sample      = 1'b0;
        w_frame_start = 1'b0;
        w_byte_ok     = 1'b0;
        case (r_rx_state)
            c_rx_idle: begin
                w_cnt_clr = 1'b1;
                if (w_rx_fall) begin
                    w_frame_start = 1'b1;
                    w_rx_nxt      = c_rx_start;
                end
            end
            c_rx_start: begin
                // Half a bit in: a line already back high was only a glitch
                if (r_rx_cnt == c_half_end) begin
                    w_cnt_clr = 1'b1;
                    w_rx_nxt  = r_rx_sync ? c_rx_idle : c_rx_data;
                end
            end
            c_rx_data: begin
                if (r_rx_cnt == c_bit_end) begin
                    w_cnt_clr = 1'b1;
                    w_sample  = 1'b1;
                    if (r_rx_bit == 3'd7) w_rx_nxt = c_rx_stop;
                end
            end
            c_rx_stop: begin
                // Leave mid-stop so an immediately following start is caught
                if (r_rx_cnt == c_bit_end) begin
                    w_cnt_clr = 1'b1;
                    w_byte_ok = r_rx_sync;
                    w_rx_nxt  = c_rx_idle;
                end
            end
            default: w_rx_nxt = c_rx_idle;
        endcase
    end

    // Bit timing, data shifter and ready flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rdy      <= 1'b0;
            r_rx_data  <= '0;
        end else begin
            r_rx_cnt <= w_cnt_clr ? '0 : r_rx_cnt + 1'b1;
            if (r_rx_state != c_rx_data) r_rx_bit <= '0;
            else if (w_sample)           r_rx_bit <= r_rx_bit + 3'd1;
            if (w_sample) r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
            // A completing byte takes priority over any clear request
            if (w_byte_ok) begin
                r_rdy     <= 1'b1;
                r_rx_data <= r_rx_shift;
            end else if (w_frame_start || clr_rdy) begin
                r_rdy <= 1'b0;
            end
        end
    end

    assign rdy     = r_rdy;
    assign rx_data = r_rx_data;

endmodule
`default_nettype wire

// File: rtl/comm_mstr.sv
`default_nettype none
// ============================================================================
// Module      : comm_mstr
// Description : Host-side command master. Sends a 16-bit command as two
//               back-to-back 8N1 bytes (high first) and captures response
//               bytes from the analyzer.
// Revision    : 1.0 - initial release
// ============================================================================
module comm_mstr
    import la_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cmd,
    input  logic        send_cmd,
    output logic        cmd_sent,
    output logic        TX,
    input  logic        RX,
    output logic [7:0]  resp,
    output logic        resp_rdy,
    input  logic        clr_resp_rdy
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_high = 2'd1;
    localparam logic [1:0] c_st_low  = 2'd2;

    logic [1:0] r_state;
    logic [1:0] w_nxt_state;
    logic [7:0] r_low_byte;
    logic       r_cmd_sent;
    logic       w_trmt;
    logic [7:0] w_tx_data;
    logic       w_tx_done;
    logic       w_accept;
    logic       w_set_sent;
    logic       w_clr_rdy;

    // Sender state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_st_idle;
        else        r_state <= w_nxt_state;
    end

    // Sender next state; the low byte is handed over on tx_done for a gapless pair
    always_comb begin
        w_nxt_state = r_state;
        w_trmt      = 1'b0;
        w_tx_data   = cmd[15:8];
        w_accept    = 1'b0;
        w_set_sent  = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (send_cmd) begin
                    w_accept    = 1'b1;
                    w_trmt      = 1'b1;
                    w_nxt_state = c_st_high;
                end
            end
            c_st_high: begin
                if (w_tx_done) begin
                    w_trmt      = 1'b1;
                    w_tx_data   = r_low_byte;
                    w_nxt_state = c_st_low;
                end
            end
            c_st_low: begin
                if (w_tx_done) begin
                    w_set_sent  = 1'b1;
                    w_nxt_state = c_st_idle;
                end
            end
            default: w_nxt_state = c_st_idle;
        endcase
    end

    // Low-byte holding register and sticky completion flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_low_byte <= '0;
            r_cmd_sent <= 1'b0;
        end else begin
            if (w_accept) begin
                r_low_byte <= cmd[7:0];
                r_cmd_sent <= 1'b0;
            end else if (w_set_sent) begin
                r_cmd_sent <= 1'b1;
            end
        end
    end

    // A new command also drops any stale response flag
    assign w_clr_rdy = clr_resp_rdy | w_accept;
    assign cmd_sent  = r_cmd_sent;

    comm_uart #(
        .BAUD_DIV (BAUD_DIV)
    ) u_uart (
        .clk     (clk),
        .rst_n   (rst_n),
        .trmt    (w_trmt),
        .tx_data (w_tx_data),
        .tx_done (w_tx_done),
        .TX      (TX),
        .RX      (RX),
        .clr_rdy (w_clr_rdy),
        .rdy     (resp_rdy),
        .rx_data (resp)
    );

endmodule
`default_nettype wire

// File: tb/tb_comm_mstr.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_comm_mstr
// Description : Self-checking bench for comm_mstr: TX decoder and RX
//               scoreboard, table-driven receive vectors, corner sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_comm_mstr;
    import la_pkg::*;

    localparam int c_bd      = 16;
    localparam int c_bd_slow = BAUD_DIV_DEFAULT;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] cmd;
    logic        send_cmd;
    logic        clr_resp_rdy;
    logic        cmd_sent;
    logic        tx;
    logic        rx;
    logic        rx_drv;
    logic        loop_en;
    logic [7:0]  resp;
    logic        resp_rdy;

    logic        rx_slow;
    logic        cmd_sent_s;
    logic        tx_s;
    logic [7:0]  resp_s;
    logic        resp_rdy_s;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  exp_tx_q[$];
    logic [7:0]  exp_rx_q[$];
    int          rdy_rises = 0;
    int          tx_frames = 0;
    bit          tx_mon_en = 1'b1;
    logic        mon_prev  = 1'b0;
    logic        tx_prev   = 1'b1;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       glitch;
        logic       exp_rdy;
        logic [7:0] exp_resp;
    } rx_vec_t;
    rx_vec_t vecs [7];

    always #5 clk = ~clk;

    assign rx = loop_en ? tx : rx_drv;

    comm_mstr #(.BAUD_DIV(c_bd)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd          (cmd),
        .send_cmd     (send_cmd),
        .cmd_sent     (cmd_sent),
        .TX           (tx),
        .RX           (rx),
        .resp         (resp),
        .resp_rdy     (resp_rdy),
        .clr_resp_rdy (clr_resp_rdy)
    );

    comm_mstr dut_slow (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd          (16'h0000),
        .send_cmd     (1'b0),
        .cmd_sent     (cmd_sent_s),
        .TX           (tx_s),
        .RX           (rx_slow),
        .resp         (resp_s),
        .resp_rdy     (resp_rdy_s),
        .clr_resp_rdy (1'b0)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Drive one 8N1 frame; good frames on the fast DUT go to the scoreboard
    task automatic drive_rx(input bit slow, input logic [7:0] b, input logic stop, input int bd);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        if (!slow && stop) exp_rx_q.push_back(b);
        for (int i = 0; i < 10; i++) begin
            if (slow) rx_slow = f[i];
            else      rx_drv  = f[i];
            tick(bd);
        end
        if (slow) rx_slow = 1'b1;
        else      rx_drv  = 1'b1;
    endtask

    // Issue a command and count clocks until cmd_sent; optional second pulse while busy
    task automatic do_send(input logic [15:0] c, input int busy_at, output int lat);
        cmd      = c;
        send_cmd = 1'b1;
        exp_tx_q.push_back(c[15:8]);
        exp_tx_q.push_back(c[7:0]);
        tick(1);
        send_cmd = 1'b0;
        lat      = 1;
        while (cmd_sent !== 1'b1 && lat < 25 * c_bd) begin
            if (lat == busy_at) begin
                cmd      = 16'h1234;
                send_cmd = 1'b1;
            end else begin
                send_cmd = 1'b0;
            end
            tick(1);
            lat++;
        end
        send_cmd = 1'b0;
    endtask

    // Response scoreboard: every resp_rdy rising edge pops one expected byte
    initial begin
        forever begin
            tick(1);
            if (resp_rdy === 1'b1 && mon_prev === 1'b0) begin
                rdy_rises++;
                if (exp_rx_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL resp_unexpected: got %0h, required no byte", resp);
                end else begin
                    check("resp_sb", resp, exp_rx_q.pop_front());
                end
            end
            mon_prev = resp_rdy;
        end
    end

    // TX decoder: mid-bit sampling of every frame against the expected byte queue
    initial begin
        logic [7:0] b;
        logic       st;
        logic       sp;
        forever begin
            tick(1);
            if (tx_prev === 1'b1 && tx === 1'b0) begin
                tick(c_bd / 2);
                st = tx;
                for (int i = 0; i < 8; i++) begin
                    tick(c_bd);
                    b[i] = tx;
                end
                tick(c_bd);
                sp = tx;
                if (tx_mon_en) begin
                    tx_frames++;
                    check("tx_start", st, 1'b0);
                    check("tx_stop", sp, 1'b1);
                    if (exp_tx_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL tx_unexpected: got %0h, required no frame", b);
                    end else begin
                        check("tx_byte", b, exp_tx_q.pop_front());
                    end
                end
            end
            tx_prev = tx;
        end
    end

    // Watchdog
    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int r0;
        int f0;

        vecs[0] = '{ACK_POS, 1'b1, 1'b0, 1'b1, ACK_POS};
        vecs[1] = '{ACK_NEG, 1'b1, 1'b0, 1'b1, ACK_NEG};
        vecs[2] = '{8'h77,   1'b0, 1'b0, 1'b0, ACK_NEG};
        vecs[3] = '{8'h00,   1'b1, 1'b0, 1'b1, 8'h00};
        vecs[4] = '{8'hFF,   1'b1, 1'b0, 1'b1, 8'hFF};
        vecs[5] = '{8'h00,   1'b1, 1'b1, 1'b0, 8'hFF};
        vecs[6] = '{8'h3C,   1'b1, 1'b0, 1'b1, 8'h3C};

        rst_n        = 1'b0;
        cmd          = 16'h0000;
        send_cmd     = 1'b0;
        clr_resp_rdy = 1'b0;
        rx_drv       = 1'b1;
        rx_slow      = 1'b1;
        loop_en      = 1'b0;
        tick(3);
        check("rst_tx", tx, 1'b1);
        check("rst_cmd_sent", cmd_sent, 1'b0);
        check("rst_resp", resp, 8'h00);
        check("rst_resp_rdy", resp_rdy, 1'b0);
        rst_n = 1'b1;
        tick(4);

        // Transmit 0x4110
        do_send(16'h4110, -1, lat);
        check("tx_latency", lat, 20 * c_bd + 1);
        tick(c_bd);
        check("tx_queue_empty", exp_tx_q.size(), 0);
        check("cmd_sent_sticky", cmd_sent, 1'b1);

        // Receive vectors
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].glitch) begin
                rx_drv = 1'b0;
                tick(c_bd / 4);
                rx_drv = 1'b1;
                tick(10 * c_bd);
            end else begin
                drive_rx(1'b0, vecs[i].data, vecs[i].stop, c_bd);
            end
            check($sformatf("vec%0d_rdy", i), resp_rdy, vecs[i].exp_rdy);
            check($sformatf("vec%0d_resp", i), resp, vecs[i].exp_resp);
            clr_resp_rdy = 1'b1;
            tick(1);
            clr_resp_rdy = 1'b0;
            check($sformatf("vec%0d_clr_rdy", i), resp_rdy, 1'b0);
            check($sformatf("vec%0d_resp_held", i), resp, vecs[i].exp_resp);
        end

        // Back-to-back receive
        r0 = rdy_rises;
        drive_rx(1'b0, 8'h11, 1'b1, c_bd);
        drive_rx(1'b0, 8'h22, 1'b1, c_bd);
        drive_rx(1'b0, 8'h33, 1'b1, c_bd);
        tick(2);
        check("b2b_rises", rdy_rises - r0, 3);
        check("b2b_resp", resp, 8'h33);
        check("b2b_queue_empty", exp_rx_q.size(), 0);

        // Loopback
        loop_en = 1'b1;
        r0 = rdy_rises;
        exp_rx_q.push_back(8'h4F);
        exp_rx_q.push_back(8'h00);
        do_send(16'h4F00, -1, lat);
        tick(c_bd);
        check("loop_latency", lat, 20 * c_bd + 1);
        check("loop_rises", rdy_rises - r0, 2);
        check("loop_resp", resp, 8'h00);
        check("loop_rx_queue_empty", exp_rx_q.size(), 0);
        loop_en = 1'b0;
        tick(2);

        // Second send_cmd while the high byte is in flight
        f0 = tx_frames;
        do_send({SET_TRG_CFG, 8'hAB}, 3 * c_bd, lat);
        check("busy_latency", lat, 20 * c_bd + 1);
        tick(12 * c_bd);
        check("busy_frames", tx_frames - f0, 2);
        check("busy_tx_queue_empty", exp_tx_q.size(), 0);
        check("busy_cmd_sent", cmd_sent, 1'b1);

        // Reset mid-frame
        tx_mon_en = 1'b0;
        cmd       = 16'h4122;
        send_cmd  = 1'b1;
        tick(1);
        send_cmd  = 1'b0;
        drive_rx(1'b0, 8'h5A, 1'b1, c_bd);
        check("pre_rst_tx", tx, 1'b0);
        check("pre_rst_resp_rdy", resp_rdy, 1'b1);
        check("pre_rst_resp", resp, 8'h5A);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx", tx, 1'b1);
        check("mid_rst_cmd_sent", cmd_sent, 1'b0);
        check("mid_rst_resp", resp, 8'h00);
        check("mid_rst_resp_rdy", resp_rdy, 1'b0);
        tick(2);
        rst_n = 1'b1;
        tick(12 * c_bd);
        exp_tx_q.delete();
        tx_mon_en = 1'b1;

        // Normal command after reset
        do_send({DUMP_CH1, 8'h12}, -1, lat);
        check("post_rst_latency", lat, 20 * c_bd + 1);
        tick(c_bd);
        check("post_rst_tx_queue_empty", exp_tx_q.size(), 0);

        // Default divisor
        drive_rx(1'b1, ACK_NEG, 1'b1, c_bd_slow);
        check("slow_resp", resp_s, ACK_NEG);
        check("slow_resp_rdy", resp_rdy_s, 1'b1);
        check("slow_tx_idle", tx_s, 1'b1);
        check("slow_cmd_sent", cmd_sent_s, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
